// File: rtl/usr_seq.sv
// Command sequencer driving a universal shift register (load / shift down / shift up / rotate).
// Optional macro USR_SEQ_ROT_EN: op 11 rotates down via usr_q feedback; otherwise op 11 is a timed hold.
module usr_seq #(
  parameter int SIZE = 4,
  parameter int CW   = $clog2(SIZE) + 1
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [1:0]      cmd_op,
  input  logic [CW-1:0]   cmd_cnt,
  input  logic [SIZE-1:0] cmd_data,
  input  logic [SIZE-1:0] usr_q,
  output logic            sel0,
  output logic            sel1,
  output logic            left,
  output logic            right,
  output logic [SIZE-1:0] i,
  output logic            busy,
  output logic            done
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_SDN  = 2'b01;
  localparam logic [1:0] OP_SUP  = 2'b10;
  localparam logic [1:0] OP_ROT  = 2'b11;

  typedef struct packed {
    logic [1:0]      op;
    logic [CW-1:0]   rem;
    logic [SIZE-1:0] sbuf;
  } cmd_t;

  state_t state, state_nxt;
  cmd_t   cmd_r;
  logic   accept;
  logic   [1:0] sel;

  assign accept = (state == IDLE) && cmd_valid;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (cmd_valid)
              state_nxt = (cmd_op != OP_LOAD && cmd_cnt == '0) ? FIN : RUN;
      RUN:  if (cmd_r.rem == CW'(1)) state_nxt = FIN;
      FIN:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Serial source drains LSB-first with zero fill, so counts beyond SIZE shift in zeros.
  always_ff @(posedge clk) begin
    if (clear) begin
      cmd_r <= '0;
    end else if (accept) begin
      cmd_r.op   <= cmd_op;
      cmd_r.rem  <= (cmd_op == OP_LOAD) ? CW'(1) : cmd_cnt;
      cmd_r.sbuf <= cmd_data;
    end else if (state == RUN) begin
      cmd_r.rem  <= cmd_r.rem - CW'(1);
      cmd_r.sbuf <= cmd_r.sbuf >> 1;
    end
  end

  always_comb begin
    sel       = 2'b00;
    left      = 1'b0;
    right     = 1'b0;
    i         = '0;
    cmd_ready = (state == IDLE);
    busy      = (state == RUN);
    done      = (state == FIN);
    if (state == RUN) begin
      case (cmd_r.op)
        OP_LOAD: begin sel = 2'b11; i     = cmd_r.sbuf;    end
        OP_SDN:  begin sel = 2'b01; right = cmd_r.sbuf[0]; end
        OP_SUP:  begin sel = 2'b10; left  = cmd_r.sbuf[0]; end
`ifdef USR_SEQ_ROT_EN
        OP_ROT:  begin sel = 2'b01; right = usr_q[0];      end
`else
        OP_ROT:  sel = 2'b00;
`endif
        default: sel = 2'b00;
      endcase
    end
  end

  assign sel1 = sel[1];
  assign sel0 = sel[0];

  // Only bit 0 of the feedback matters, and only when rotation is built in.
  logic unused_q;
`ifdef USR_SEQ_ROT_EN
  assign unused_q = ^usr_q[SIZE-1:1];
`else
  assign unused_q = ^usr_q;
`endif

endmodule
